// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, subordinate FSM states and the byte-lane mask helper
// used by the SRAM subordinate.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4,
        HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16
    } hburst_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
    } sub_state_e;

    // Little-endian lane enables for up to 8 lanes; narrower buses use the low bits.
    function automatic logic [7:0] byte_lane_mask(input logic [2:0] addr_lsb,
                                                  input logic [2:0] size);
        logic [7:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << addr_lsb;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Flop-array word memory: byte-enabled synchronous write, combinational read,
// one shared word address. Contents are never reset.
module ahb_sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                        clk,
    input  logic [DATA_WIDTH/8-1:0]     i_we,
    input  logic [$clog2(DEPTH)-1:0]    i_addr,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    output logic [DATA_WIDTH-1:0]       o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_sram_subordinate.sv
// AHB-lite SRAM subordinate: address-phase decode, wait-state/error FSM and
// byte-lane write control in front of a flop-array memory.
module ahb_lite_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADY,
    output logic                    HRESP
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int BSH = $clog2(NB);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam int CW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    sub_state_e             r_state, w_next;
    logic [CW-1:0]          r_cnt, w_cnt_next;
    logic [IW-1:0]          r_idx;
    logic [BSH-1:0]         r_lsb;
    logic [2:0]             r_size;
    logic                   r_write;
    logic                   w_sample, w_err;
    logic [ADDR_WIDTH-1:0]  w_align;
    logic [7:0]             w_lmask;
    logic [NB-1:0]          w_we;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic                   w_unused;

    assign w_sample = HREADY && HSEL && (htrans_e'(HTRANS) inside {HT_NONSEQ, HT_SEQ});
    assign w_align  = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
    assign w_err    = ((HADDR >> BSH) >= ADDR_WIDTH'(MEM_DEPTH)) ||
                      (HSIZE > 3'(BSH)) ||
                      ((HADDR & w_align) != '0);

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Address-phase capture only; a stale value is harmless outside DATA.
    always_ff @(posedge clk) begin
        if (w_sample) begin
            r_idx   <= HADDR[BSH +: IW];
            r_lsb   <= HADDR[BSH-1:0];
            r_size  <= HSIZE;
            r_write <= HWRITE;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_WAIT: begin
                if (int'(r_cnt) == WAIT_STATES) begin
                    w_next     = S_DATA;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_ERR1: w_next = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all end with HREADY high, so all may accept.
                if (!w_sample)        w_next = S_IDLE;
                else if (w_err)       w_next = S_ERR1;
                else if (WAIT_STATES > 0) begin
                    w_next     = S_WAIT;
                    w_cnt_next = CW'(1);
                end else              w_next = S_DATA;
            end
        endcase
    end

    assign HREADY  = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign HRESP   = (r_state == S_ERR1 || r_state == S_ERR2) ? RESP_ERROR : RESP_OKAY;
    assign HRDATA  = (r_state == S_DATA && !r_write) ? w_rdata : '0;
    assign w_lmask = byte_lane_mask(3'(r_lsb), r_size);
    assign w_we    = (r_state == S_DATA && r_write) ? w_lmask[NB-1:0] : '0;

    assign w_unused = ^{HBURST, HPROT, w_lmask};

    ahb_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

endmodule
